// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared definitions for the MIPS execute-stage ALU.
//   ALU_CTRL_W : width of the operation select code.
//   alu_op_e   : the 16 operation codes.
package mips_alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_LSH  = 4'd5,
        ALU_RSH  = 4'd6,
        ALU_NAND = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_XNOR = 4'd9,
        ALU_NOT  = 4'd10,
        ALU_COMP = 4'd11,
        ALU_ADDO = 4'd12,
        ALU_SUBO = 4'd13,
        ALU_SIG  = 4'd14,
        ALU_SOME = 4'd15
    } alu_op_e;

endpackage

// File: rtl/mips_alu_adder.sv
// mips_alu_adder: W-bit adder with carry-in, built as one W+1-bit sum.
//   a, b : operands (b arrives already inverted for subtraction)
//   cin  : carry in
//   sum  : W-bit result, wraps modulo 2^W
//   cout : carry out of bit W-1
//   ovf  : signed two's-complement overflow of a + b + cin
module mips_alu_adder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ovf
);

    logic [DATA_WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
    assign sum  = full[DATA_WIDTH-1:0];
    assign cout = full[DATA_WIDTH];
    // Overflow: operands share a sign but the result sign differs.
    assign ovf  = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                  (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);

endmodule

// File: rtl/mips_alu.sv
// mips_alu: 16-operation integer ALU for the MIPS execute stage.
//   clk, rst : clock and synchronous active-high reset
//   rega     : operand A
//   regb     : operand B (low log2(DATA_WIDTH) bits are the shift amount)
//   control  : operation select (mips_alu_pkg::alu_op_e)
//   out_alu  : result
//   cout     : carry / no-borrow / signed overflow, depending on operation
//   equal    : rega == regb
//   zero     : out_alu == 0
// Build option: define ALU_OUT_REG_EN to register all four outputs
// (one-cycle latency, cleared by rst). Default build is combinational.
// An internal carry register feeds the add-with-carry (SOME) operation.
module mips_alu
    import mips_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rega,
    input  logic [DATA_WIDTH-1:0] regb,
    input  logic [ALU_CTRL_W-1:0] control,
    output logic [DATA_WIDTH-1:0] out_alu,
    output logic                  cout,
    output logic                  equal,
    output logic                  zero
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    alu_op_e               op;
    logic                  carry_q;
    logic                  sub_sel;
    logic [DATA_WIDTH-1:0] add_b;
    logic                  add_cin;
    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_cout;
    logic                  add_ovf;
    logic [SH_W-1:0]       shamt;

    logic [DATA_WIDTH-1:0] res_p0;
    logic                  cout_p0;
    logic                  eq_p0;
    logic                  zero_p0;

    assign op    = alu_op_e'(control);
    assign shamt = regb[SH_W-1:0];

    // Subtraction is A + ~B + 1; SOME injects the stored carry instead.
    always_comb begin
        sub_sel = (op == ALU_SUB) || (op == ALU_SUBO) || (op == ALU_SIG);
        add_b   = sub_sel ? ~regb : regb;
        if (sub_sel)
            add_cin = 1'b1;
        else if (op == ALU_SOME)
            add_cin = carry_q;
        else
            add_cin = 1'b0;
    end

    mips_alu_adder #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_adder (
        .a    (rega),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Stage p0: combinational result and flags.
    always_comb begin
        res_p0  = '0;
        cout_p0 = 1'b0;
        eq_p0   = (rega == regb);
        case (op)
            ALU_ADD:  begin res_p0 = add_sum; cout_p0 = add_cout; end
            ALU_SUB:  begin res_p0 = add_sum; cout_p0 = add_cout; end
            ALU_AND:  res_p0 = rega & regb;
            ALU_OR:   res_p0 = rega | regb;
            ALU_XOR:  res_p0 = rega ^ regb;
            ALU_LSH:  res_p0 = rega << shamt;
            ALU_RSH:  res_p0 = rega >> shamt;
            ALU_NAND: res_p0 = ~(rega & regb);
            ALU_NOR:  res_p0 = ~(rega | regb);
            ALU_XNOR: res_p0 = ~(rega ^ regb);
            ALU_NOT:  res_p0 = ~rega;
            ALU_COMP: res_p0 = {{(DATA_WIDTH-1){1'b0}}, eq_p0};
            ALU_ADDO: begin res_p0 = add_sum; cout_p0 = add_ovf; end
            ALU_SUBO: begin res_p0 = add_sum; cout_p0 = add_ovf; end
            // A - B is negative in true (overflow-corrected) sign.
            ALU_SIG:  res_p0 = {{(DATA_WIDTH-1){1'b0}}, add_sum[DATA_WIDTH-1] ^ add_ovf};
            ALU_SOME: begin res_p0 = add_sum; cout_p0 = add_cout; end
            default:  res_p0 = '0;
        endcase
        zero_p0 = (res_p0 == '0);
    end

    always_ff @(posedge clk) begin
        if (rst)
            carry_q <= 1'b0;
        else if (op == ALU_ADD || op == ALU_SUB || op == ALU_SOME)
            carry_q <= cout_p0;
    end

`ifdef ALU_OUT_REG_EN
    logic [DATA_WIDTH-1:0] res_p1;
    logic                  cout_p1;
    logic                  eq_p1;
    logic                  zero_p1;

    // Stage p1: registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_p1  <= '0;
            cout_p1 <= 1'b0;
            eq_p1   <= 1'b0;
            zero_p1 <= 1'b0;
        end else begin
            res_p1  <= res_p0;
            cout_p1 <= cout_p0;
            eq_p1   <= eq_p0;
            zero_p1 <= zero_p0;
        end
    end

    assign out_alu = res_p1;
    assign cout    = cout_p1;
    assign equal   = eq_p1;
    assign zero    = zero_p1;
`else
    assign out_alu = res_p0;
    assign cout    = cout_p0;
    assign equal   = eq_p0;
    assign zero    = zero_p0;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: scoreboard bench for mips_alu (DATA_WIDTH = 32).
// Works in both the default build and with ALU_OUT_REG_EN defined.
module tb_mips_alu;
    import mips_alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] rega;
    logic [W-1:0] regb;
    logic [3:0]   control;
    logic [W-1:0] out_alu;
    logic         cout;
    logic         equal;
    logic         zero;

    always #5 clk = ~clk;

    mips_alu #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .rega    (rega),
        .regb    (regb),
        .control (control),
        .out_alu (out_alu),
        .cout    (cout),
        .equal   (equal),
        .zero    (zero)
    );

    typedef struct packed {
        logic [W-1:0] out;
        logic         cout;
        logic         eq;
        logic         zero;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  carry_m = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Independent reference: plain integer arithmetic and comparisons.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t        e;
        logic [W:0]  s;
        longint      r;
        e = '0;
        case (op)
            4'd0:  begin s = {1'b0, a} + {1'b0, b}; e.out = s[W-1:0]; e.cout = s[W]; end
            4'd1:  begin e.out = a - b; e.cout = (a >= b); end
            4'd2:  e.out = a & b;
            4'd3:  e.out = a | b;
            4'd4:  e.out = a ^ b;
            4'd5:  e.out = a << b[4:0];
            4'd6:  e.out = a >> b[4:0];
            4'd7:  e.out = ~(a & b);
            4'd8:  e.out = ~(a | b);
            4'd9:  e.out = ~(a ^ b);
            4'd10: e.out = ~a;
            4'd11: e.out = (a == b) ? 32'd1 : 32'd0;
            4'd12: begin
                e.out  = a + b;
                r      = longint'($signed(a)) + longint'($signed(b));
                e.cout = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd13: begin
                e.out  = a - b;
                r      = longint'($signed(a)) - longint'($signed(b));
                e.cout = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd14: e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                e.out = s[W-1:0]; e.cout = s[W];
            end
        endcase
        e.eq   = (a == b);
        e.zero = (e.out == '0);
        return e;
    endfunction

    task automatic collect();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "_out"},   out_alu, e.out);
            check({t, "_cout"},  {31'd0, cout},  {31'd0, e.cout});
            check({t, "_equal"}, {31'd0, equal}, {31'd0, e.eq});
            check({t, "_zero"},  {31'd0, zero},  {31'd0, e.zero});
        end
    endtask

    // One operation per clock: drive on negedge, sample before the next
    // posedge (combinational) or just after it (registered outputs).
    task automatic issue(input string tag, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        control = op;
        rega    = a;
        regb    = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
`ifdef ALU_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #2;
`endif
        collect();
        if (!rst && (op == 4'd0 || op == 4'd1 || op == 4'd15))
            carry_m = e.cout;
    endtask

    // Directed vector with the expected result and flag written out by hand.
    task automatic vec(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] xout, input logic xcout);
        exp_t e;
        e.out  = xout;
        e.cout = xcout;
        e.eq   = (a == b);
        e.zero = (xout == '0);
        issue(tag, op, a, b, e);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst     = 1'b1;
        control = 4'd0;
        rega    = 32'd10;
        regb    = 32'd20;
        @(posedge clk);
        #1;
`ifdef ALU_OUT_REG_EN
        check("rst_out",   out_alu, 32'd0);
        check("rst_cout",  {31'd0, cout},  32'd0);
        check("rst_equal", {31'd0, equal}, 32'd0);
        check("rst_zero",  {31'd0, zero},  32'd0);
`else
        check("rst_comb_out",  out_alu, 32'd30);
        check("rst_comb_zero", {31'd0, zero}, 32'd0);
`endif
        carry_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst     = 1'b1;
        control = 4'd0;
        rega    = '0;
        regb    = '0;
        pulse_reset();

        vec("some_after_rst", 4'd15, 32'd1, 32'd1, 32'd2, 1'b0);

        vec("add_10_20",   4'd0, 32'd10, 32'd20, 32'd30, 1'b0);
        vec("add_wrap",    4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        vec("sub_50_20",   4'd1, 32'd50, 32'd20, 32'd30, 1'b1);
        vec("sub_10_10",   4'd1, 32'd10, 32'd10, 32'd0, 1'b1);
        vec("sub_0_1",     4'd1, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);

        vec("and",  4'd2,  32'h00FF, 32'h0F0F, 32'h0000000F, 1'b0);
        vec("or",   4'd3,  32'h00FF, 32'h0F0F, 32'h00000FFF, 1'b0);
        vec("xor",  4'd4,  32'h00FF, 32'h0F0F, 32'h00000FF0, 1'b0);
        vec("nand", 4'd7,  32'h00FF, 32'h0F0F, 32'hFFFFFFF0, 1'b0);
        vec("nor",  4'd8,  32'h00FF, 32'h0F0F, 32'hFFFFF000, 1'b0);
        vec("xnor", 4'd9,  32'h00FF, 32'h0F0F, 32'hFFFFF00F, 1'b0);
        vec("not",  4'd10, 32'h00FF, 32'h0F0F, 32'hFFFFFF00, 1'b0);

        vec("lsh_31",     4'd5,  32'd1, 32'd31, 32'h80000000, 1'b0);
        vec("rsh_35",     4'd6,  32'h80000000, 32'd35, 32'h10000000, 1'b0);
        vec("comp_eq",    4'd11, 32'd100, 32'd100, 32'd1, 1'b0);
        vec("comp_ne",    4'd11, 32'd100, 32'd101, 32'd0, 1'b0);
        vec("sig_neg",    4'd14, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        vec("sig_pos",    4'd14, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);

        vec("addo_ovf",   4'd12, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1);
        vec("subo_ovf",   4'd13, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1);
        vec("addo_small", 4'd12, 32'd5, 32'd3, 32'd8, 1'b0);

        vec("chain_add",  4'd0,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        vec("chain_some", 4'd15, 32'd1, 32'd1, 32'd3, 1'b0);

        vec("pre_rst_add", 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        pulse_reset();
        vec("some_post_rst", 4'd15, 32'd1, 32'd1, 32'd2, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            e  = model(op, a, b, carry_m);
            issue("rand", op, a, b, e);
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 1 want 0");
        $fatal(1);
    end

endmodule
